// File: rtl/rab_pkg.sv
// Shared types and constants for the RAB lookup arbiter.
package rab_pkg;

    localparam int unsigned RAB_ADDR_WIDTH = 32;

    // One-hot winner encoding produced by the round-robin picker.
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_SENT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rab_lookup_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request always wins, a tie goes to the
// port that was not served last.
module rab_rr_arb2
    import rab_pkg::*;
(
    input  logic       i_req1,
    input  logic       i_req2,
    input  logic       i_last_p1,   // 1 = port 1 served last, 0 = port 2
    output logic [1:0] o_win
);

    // Pick the winner from the current requests and the round-robin pointer.
    always_comb begin
        o_win = WIN_NONE;
        if (i_req1 && i_req2) begin
            o_win = i_last_p1 ? WIN_P2 : WIN_P1;
        end else if (i_req1) begin
            o_win = WIN_P1;
        end else if (i_req2) begin
            o_win = WIN_P2;
        end
    end

endmodule

// File: rtl/rab_lookup_arbiter.sv
// Arbitrates the read (port 1) and write (port 2) channels for a single
// shared address-translation lookup engine.
// Optional feature: define RAB_ARB_TIMEOUT_EN to abort a lookup that has not
// reported completion within TIMEOUT_CYCLES cycles (adds timeout_irq).
module rab_lookup_arbiter
    import rab_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = RAB_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic                  port1_req,
    input  logic [ADDR_WIDTH-1:0] port1_addr,
    input  logic                  port2_req,
    input  logic [ADDR_WIDTH-1:0] port2_addr,
    output logic                  lookup_p1_valid,
    output logic                  lookup_p2_valid,
    output logic                  lookup_select,
    output logic [ADDR_WIDTH-1:0] lookup_addr,
    input  logic                  lookup_p1_sent,
    input  logic                  lookup_p2_sent,
    output logic                  port1_grant,
    output logic                  port2_grant,
    output logic                  busy
`ifdef RAB_ARB_TIMEOUT_EN
   ,output logic                  timeout_irq
`endif
);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic [1:0]            w_win;
    logic                  w_issue;
    logic                  w_done;
    logic                  w_abort;
    logic                  w_own_sent;
    logic                  w_tmo_hit;
    logic                  r_last_p1;
    logic                  r_select;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_p1_valid;
    logic                  r_p2_valid;
    logic                  r_p1_grant;
    logic                  r_p2_grant;

    rab_rr_arb2 u_rr_arb2 (
        .i_req1    (port1_req),
        .i_req2    (port2_req),
        .i_last_p1 (r_last_p1),
        .o_win     (w_win)
    );

`ifdef RAB_ARB_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT_CYCLES-1: the abort is decided in
    // the last allowed WAIT_SENT cycle.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_tmo_irq;

    assign w_tmo_hit = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count WAIT_SENT cycles; held at zero elsewhere so it is clear on entry.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT_SENT) begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // One-cycle abort pulse.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_tmo_irq <= 1'b0;
        end else begin
            r_tmo_irq <= w_abort;
        end
    end

    assign timeout_irq = r_tmo_irq;
`else
    logic w_unused_tmo_cfg;

    assign w_tmo_hit        = 1'b0;
    assign w_unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Next-state decode plus the issue/complete/abort events it implies.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        w_own_sent   = r_select ? lookup_p1_sent : lookup_p2_sent;
        case (r_state)
            IDLE: begin
                if (w_win != WIN_NONE) begin
                    w_state_next = ISSUE;
                    w_issue      = 1'b1;
                end
            end
            ISSUE: begin
                w_state_next = WAIT_SENT;
            end
            WAIT_SENT: begin
                // Completion wins over a coincident timeout.
                if (w_own_sent) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch owner and its address on IDLE exit; held until the next IDLE exit.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_select <= 1'b0;
            r_addr   <= '0;
        end else if (w_issue) begin
            r_select <= (w_win == WIN_P1);
            r_addr   <= (w_win == WIN_P1) ? port1_addr : port2_addr;
        end
    end

    // Issue strobes and completion grants, each a single-cycle pulse.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_p1_valid <= 1'b0;
            r_p2_valid <= 1'b0;
            r_p1_grant <= 1'b0;
            r_p2_grant <= 1'b0;
        end else begin
            r_p1_valid <= w_issue && (w_win == WIN_P1);
            r_p2_valid <= w_issue && (w_win == WIN_P2);
            r_p1_grant <= w_done && r_select;
            r_p2_grant <= w_done && !r_select;
        end
    end

    // Round-robin pointer; reset favours port 1 on the first tie.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_last_p1 <= 1'b0;
        end else if (w_done || w_abort) begin
            r_last_p1 <= r_select;
        end
    end

    assign lookup_p1_valid = r_p1_valid;
    assign lookup_p2_valid = r_p2_valid;
    assign lookup_select   = r_select;
    assign lookup_addr     = r_addr;
    assign port1_grant     = r_p1_grant;
    assign port2_grant     = r_p2_grant;
    assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_rab_lookup_arbiter.sv
// Self-checking bench for rab_lookup_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
// Define RAB_ARB_TIMEOUT_EN to also exercise the timeout feature.
module tb_rab_lookup_arbiter;

`ifdef RAB_ARB_TIMEOUT_EN
    localparam int TMO    = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 255;
    localparam bit TMO_EN = 1'b0;
`endif

    logic        s_axi_aclk   = 1'b0;
    logic        s_axi_areset = 1'b0;
    logic        port1_req    = 1'b0;
    logic [31:0] port1_addr   = '0;
    logic        port2_req    = 1'b0;
    logic [31:0] port2_addr   = '0;
    logic        lookup_p1_sent = 1'b0;
    logic        lookup_p2_sent = 1'b0;
    logic        lookup_p1_valid;
    logic        lookup_p2_valid;
    logic        lookup_select;
    logic [31:0] lookup_addr;
    logic        port1_grant;
    logic        port2_grant;
    logic        busy;
    logic        timeout_irq;

`ifndef RAB_ARB_TIMEOUT_EN
    assign timeout_irq = 1'b0;
`endif

    rab_lookup_arbiter #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .s_axi_aclk      (s_axi_aclk),
        .s_axi_areset    (s_axi_areset),
        .port1_req       (port1_req),
        .port1_addr      (port1_addr),
        .port2_req       (port2_req),
        .port2_addr      (port2_addr),
        .lookup_p1_valid (lookup_p1_valid),
        .lookup_p2_valid (lookup_p2_valid),
        .lookup_select   (lookup_select),
        .lookup_addr     (lookup_addr),
        .lookup_p1_sent  (lookup_p1_sent),
        .lookup_p2_sent  (lookup_p2_sent),
        .port1_grant     (port1_grant),
        .port2_grant     (port2_grant),
        .busy            (busy)
`ifdef RAB_ARB_TIMEOUT_EN
       ,.timeout_irq     (timeout_irq)
`endif
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: who owns the engine, for how many cycles.
    int          m_owner;   // 0 none, 1 port 1, 2 port 2
    int          m_age;     // cycles since issue (0 = issue cycle)
    int          m_last;    // port served (or aborted) last
    logic        m_sel;
    logic [31:0] m_addr;
    logic        e_v1, e_v2, e_g1, e_g2, e_irq, e_busy;
    int          resp_delay;
    int          gq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_age   = 0;
        m_last  = 2;
        m_sel   = 1'b0;
        m_addr  = '0;
        e_v1 = 0; e_v2 = 0; e_g1 = 0; e_g2 = 0; e_irq = 0; e_busy = 0;
    endtask

    // Advance the model by one clock using the inputs present this cycle.
    task automatic model_step();
        logic r1, r2, s;
        int   w;
        r1 = port1_req;
        r2 = port2_req;
        e_v1 = 0; e_v2 = 0; e_g1 = 0; e_g2 = 0; e_irq = 0;
        if (m_owner == 0) begin
            if (r1 || r2) begin
                if (r1 && r2) w = (m_last == 1) ? 2 : 1;
                else          w = r1 ? 1 : 2;
                m_owner = w;
                m_age   = 0;
                m_sel   = (w == 1);
                m_addr  = (w == 1) ? port1_addr : port2_addr;
                if (w == 1) e_v1 = 1; else e_v2 = 1;
            end
        end else begin
            s = (m_owner == 1) ? lookup_p1_sent : lookup_p2_sent;
            if (m_age >= 1 && s) begin
                if (m_owner == 1) e_g1 = 1; else e_g2 = 1;
                m_last  = m_owner;
                m_owner = 0;
            end else if (TMO_EN && m_age >= 1 && m_age == TMO) begin
                e_irq   = 1;
                m_last  = m_owner;
                m_owner = 0;
            end else begin
                m_age++;
            end
        end
        e_busy = (m_owner != 0);
    endtask

    task automatic compare();
        chk("p1_valid", lookup_p1_valid, e_v1);
        chk("p2_valid", lookup_p2_valid, e_v2);
        chk("select",   lookup_select,   m_sel);
        chk("addr",     lookup_addr,     m_addr);
        chk("p1_grant", port1_grant,     e_g1);
        chk("p2_grant", port2_grant,     e_g2);
        chk("busy",     busy,            e_busy);
        if (TMO_EN) chk("timeout_irq", timeout_irq, e_irq);
    endtask

    // Clock once and compare DUT against the model just after the edge.
    task automatic run_cycle();
        model_step();
        @(posedge s_axi_aclk);
        #1;
        compare();
    endtask

    task automatic apply_reset();
        s_axi_areset   = 1'b1;
        port1_req      = 1'b0;
        port2_req      = 1'b0;
        lookup_p1_sent = 1'b0;
        lookup_p2_sent = 1'b0;
        #1;
        chk("rst_busy",     busy,            1'b0);
        chk("rst_p1_valid", lookup_p1_valid, 1'b0);
        chk("rst_p2_valid", lookup_p2_valid, 1'b0);
        chk("rst_grants",   {port1_grant, port2_grant}, 2'b00);
        chk("rst_select",   lookup_select,   1'b0);
        chk("rst_addr",     lookup_addr,     32'h0);
        chk("rst_irq",      timeout_irq,     1'b0);
        model_reset();
        repeat (2) @(posedge s_axi_aclk);
        #1;
        s_axi_areset = 1'b0;
        compare();
    endtask

    // Random requesters and lookup engine for one cycle.
    task automatic rand_stim();
        bit own;
        if (e_g1) port1_req = 1'b0;
        else if (!port1_req && $urandom_range(0, 3) == 0) begin
            port1_req  = 1'b1;
            port1_addr = $urandom;
        end
        if (e_g2) port2_req = 1'b0;
        else if (!port2_req && $urandom_range(0, 3) == 0) begin
            port2_req  = 1'b1;
            port2_addr = $urandom;
        end
        if (m_owner != 0 && m_age == 0) resp_delay = $urandom_range(1, 6);
        own = (m_owner != 0 && m_age >= 1 && m_age == resp_delay);
        lookup_p1_sent = (m_owner == 1) ? own : ($urandom_range(0, 7) == 0);
        lookup_p2_sent = (m_owner == 2) ? own : ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        model_reset();
        #2;
        apply_reset();

        // Single port 1 request: issue one cycle later, grant one cycle after sent.
        port1_req  = 1'b1;
        port1_addr = 32'h1000;
        run_cycle();
        chk("d1_p1_valid", lookup_p1_valid, 1'b1);
        chk("d1_select",   lookup_select,   1'b1);
        chk("d1_addr",     lookup_addr,     32'h1000);
        run_cycle();
        chk("d1_valid_one_cycle", lookup_p1_valid, 1'b0);
        repeat (3) run_cycle();
        lookup_p1_sent = 1'b1;
        run_cycle();
        chk("d1_p1_grant", port1_grant, 1'b1);
        chk("d1_p2_grant", port2_grant, 1'b0);
        chk("d1_busy",     busy,        1'b0);
        lookup_p1_sent = 1'b0;
        port1_req      = 1'b0;

        // Non-owning sent is ignored.
        port1_req  = 1'b1;
        port1_addr = 32'h5000;
        run_cycle();
        run_cycle();
        lookup_p2_sent = 1'b1;
        run_cycle();
        chk("d2_no_grant", {port1_grant, port2_grant}, 2'b00);
        chk("d2_busy",     busy, 1'b1);
        lookup_p2_sent = 1'b0;
        lookup_p1_sent = 1'b1;
        run_cycle();
        chk("d2_p1_grant", port1_grant, 1'b1);
        lookup_p1_sent = 1'b0;
        port1_req      = 1'b0;

        // Reset mid-transaction (last served is port 1 here, so the tie
        // after reset only goes to port 1 because reset restored it).
        port2_req  = 1'b1;
        port2_addr = 32'h2200;
        repeat (3) run_cycle();
        apply_reset();
        lookup_p2_sent = 1'b1;
        run_cycle();
        chk("d3_no_grant", {port1_grant, port2_grant}, 2'b00);
        chk("d3_busy",     busy, 1'b0);
        lookup_p2_sent = 1'b0;
        port1_req  = 1'b1;
        port1_addr = 32'h3300;
        port2_req  = 1'b1;
        port2_addr = 32'h4400;
        run_cycle();
        chk("d3_tie_p1", {lookup_p1_valid, lookup_p2_valid}, 2'b10);
        chk("d3_addr",   lookup_addr, 32'h3300);

        // Both held continuously, sent three cycles after each issue.
        for (int i = 0; i < 80 && gq.size() < 4; i++) begin
            lookup_p1_sent = (m_owner == 1 && m_age == 3);
            lookup_p2_sent = (m_owner == 2 && m_age == 3);
            run_cycle();
            if (port1_grant) gq.push_back(1);
            if (port2_grant) gq.push_back(2);
        end
        port1_req      = 1'b0;
        port2_req      = 1'b0;
        lookup_p1_sent = 1'b0;
        lookup_p2_sent = 1'b0;
        chk("d4_grant_count", gq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("d4_grant_order", (k < gq.size()) ? gq[k] : 0, (k % 2 == 0) ? 1 : 2);
        end

`ifdef RAB_ARB_TIMEOUT_EN
        // No sent: abort after TMO waiting cycles, then pending port 2 goes next.
        port1_req  = 1'b1;
        port1_addr = 32'h6000;
        run_cycle();
        port2_req  = 1'b1;
        port2_addr = 32'h7000;
        repeat (4) run_cycle();
        chk("t1_irq_early", timeout_irq, 1'b0);
        run_cycle();
        chk("t1_irq",      timeout_irq, 1'b1);
        chk("t1_no_grant", {port1_grant, port2_grant}, 2'b00);
        chk("t1_busy",     busy, 1'b0);
        run_cycle();
        chk("t1_p2_next",  {lookup_p1_valid, lookup_p2_valid}, 2'b01);
        chk("t1_addr",     lookup_addr, 32'h7000);
        // Sent in the cycle the timeout would fire resolves as a grant.
        repeat (4) run_cycle();
        lookup_p2_sent = 1'b1;
        run_cycle();
        chk("t2_grant", port2_grant, 1'b1);
        chk("t2_irq",   timeout_irq, 1'b0);
        lookup_p2_sent = 1'b0;
        port2_req      = 1'b0;
`endif

        resp_delay = 1;
        for (int c = 0; c < 3000; c++) begin
            rand_stim();
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
